// File: rtl/div_pkg.sv
// Shared widths, state encoding and protocol constants for the divider and its
// reconstruction self-check.
package div_pkg;

    localparam int unsigned QW         = 8;
    localparam int unsigned DW         = 7;
    localparam int unsigned ACC_W      = QW + DW;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned MUL_STEPS  = 8;
    localparam int unsigned DIV_WINDOW = 17;

    // Five states need three bits.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MUL  = 3'd2,
        S_ADD  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Shift-add multiplier datapath: holds quotient/divisor/remainder operands and the
// accumulator, and exposes acc + remainder for the final reconstruction step.
module mul_shift_add
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             add_rem,
    input  logic [QW-1:0]    q_in,
    input  logic [DW-1:0]    d_in,
    input  logic [DW-1:0]    r_in,
    output logic [ACC_W-1:0] acc_rem_c
);

    logic [QW-1:0]    mq;
    logic [ACC_W-1:0] md;
    logic [DW-1:0]    rr;
    logic [ACC_W-1:0] acc;

    // Worst case 255*127+127 fits in ACC_W bits, so neither sum can wrap.
    assign acc_rem_c = acc + ACC_W'(rr);

    always_ff @(posedge clk) begin
        if (reset) begin
            mq  <= '0;
            md  <= '0;
            rr  <= '0;
            acc <= '0;
        end else if (load) begin
            mq  <= q_in;
            md  <= ACC_W'(d_in);
            rr  <= r_in;
            acc <= '0;
        end else if (step) begin
            if (mq[0]) begin
                acc <= acc + md;
            end
            md <= md << 1;
            mq <= mq >> 1;
        end else if (add_rem) begin
            acc <= acc_rem_c;
        end
    end

endmodule

// File: rtl/div_reconstruct.sv
// Rebuilds dividend = quotient*divisor + remainder and flags overflow and an
// out-of-range remainder; used as an on-chip check of the sequential divider.
module div_reconstruct
    import div_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [QW-1:0] quotientin,
    input  logic [DW-1:0] divisorin,
    input  logic [DW-1:0] remainderin,
    output logic [QW-1:0] dividend,
    output logic          overflow,
    output logic          remainder_ok,
    output logic          consistent,
    output logic          valid
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic             rem_ok_q;
    logic             load_c;
    logic             step_c;
    logic             add_c;
    logic [ACC_W-1:0] acc_rem_c;
    logic             upper_set_c;

    mul_shift_add u_mul (
        .clk       (clk),
        .reset     (reset),
        .load      (load_c),
        .step      (step_c),
        .add_rem   (add_c),
        .q_in      (quotientin),
        .d_in      (divisorin),
        .r_in      (remainderin),
        .acc_rem_c (acc_rem_c)
    );

    assign upper_set_c = |acc_rem_c[ACC_W-1:QW];

    // Next state and datapath strobes; start from any state restarts at LOAD.
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        step_c    = 1'b0;
        add_c     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                load_c    = 1'b1;
                state_nxt = S_MUL;
            end
            S_MUL: begin
                step_c = 1'b1;
                if (count == LAST_STEP) state_nxt = S_ADD;
            end
            S_ADD: begin
                add_c     = 1'b1;
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (start) begin
            state_nxt = S_LOAD;
            load_c    = 1'b0;
            step_c    = 1'b0;
            add_c     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Step counter and the remainder range flag captured with the operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            rem_ok_q <= 1'b0;
        end else if (load_c) begin
            count    <= '0;
            rem_ok_q <= (divisorin != '0) && (remainderin < divisorin);
        end else if (step_c) begin
            count <= count + CNT_W'(1);
        end
    end

    // Result registers move only on the final add, so no partial product is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            dividend     <= '0;
            overflow     <= 1'b0;
            remainder_ok <= 1'b0;
            consistent   <= 1'b0;
            valid        <= 1'b0;
        end else if (start) begin
            valid <= 1'b0;
        end else if (add_c) begin
            dividend     <= acc_rem_c[QW-1:0];
            overflow     <= upper_set_c;
            remainder_ok <= rem_ok_q;
            consistent   <= ~upper_set_c & rem_ok_q;
            valid        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_reconstruct.sv
// Directed and randomized checks of div_reconstruct against an arithmetic model
// (q*d + r) and a behavioural divider for loopback.
module tb_div_reconstruct;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] quotientin;
    logic [6:0] divisorin;
    logic [6:0] remainderin;
    logic [7:0] dividend;
    logic       overflow;
    logic       remainder_ok;
    logic       consistent;
    logic       valid;

    int vectors;
    int miscompares;
    int prev_div;

    div_reconstruct dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .quotientin   (quotientin),
        .divisorin    (divisorin),
        .remainderin  (remainderin),
        .dividend     (dividend),
        .overflow     (overflow),
        .remainder_ok (remainder_ok),
        .consistent   (consistent),
        .valid        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start (sampled at E0), present operands for E1, then scramble them.
    task automatic launch(input int q, input int d, input int r);
        start = 1'b1;
        tick();
        chk("valid_drop_at_start", int'(valid), 0);
        start       = 1'b0;
        quotientin  = 8'(q);
        divisorin   = 7'(d);
        remainderin = 7'(r);
        tick();
        quotientin  = 8'($urandom);
        divisorin   = 7'($urandom);
        remainderin = 7'($urandom);
    endtask

    // Run E2..E10 and compare against the arithmetic model.
    task automatic finish_op(input string tag, input int q, input int d, input int r);
        int full;
        int exp_ovf;
        int exp_ok;
        full    = q * d + r;
        exp_ovf = (full > 255) ? 1 : 0;
        exp_ok  = (d != 0 && r < d) ? 1 : 0;
        for (int e = 2; e <= 10; e++) begin
            tick();
            if (e == 9) begin
                chk({tag, "_valid_before_E10"}, int'(valid), 0);
                chk({tag, "_dividend_held"}, int'(dividend), prev_div);
            end
        end
        chk({tag, "_valid"}, int'(valid), 1);
        chk({tag, "_dividend"}, int'(dividend), full % 256);
        chk({tag, "_overflow"}, int'(overflow), exp_ovf);
        chk({tag, "_remainder_ok"}, int'(remainder_ok), exp_ok);
        chk({tag, "_consistent"}, int'(consistent), (exp_ovf == 0 && exp_ok == 1) ? 1 : 0);
        prev_div = full % 256;
        tick();
        chk({tag, "_valid_held"}, int'(valid), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_dividend"}, int'(dividend), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_remainder_ok"}, int'(remainder_ok), 0);
        chk({tag, "_consistent"}, int'(consistent), 0);
    endtask

    initial begin
        int saw_valid;
        int n;
        int d;
        vectors     = 0;
        miscompares = 0;
        prev_div    = 0;
        reset       = 1'b1;
        start       = 1'b0;
        quotientin  = '0;
        divisorin   = '0;
        remainderin = '0;
        tick();
        tick();
        reset = 1'b0;
        chk_all_zero("reset");

        launch(5, 7, 3);
        finish_op("q5d7r3", 5, 7, 3);

        launch(255, 127, 126);
        finish_op("q255d127r126", 255, 127, 126);

        launch(3, 4, 4);
        finish_op("q3d4r4", 3, 4, 4);

        launch(200, 0, 45);
        finish_op("div_zero", 200, 0, 45);

        // Restart mid-MUL: the first operation must never report valid.
        launch(9, 2, 1);
        saw_valid = 0;
        for (int e = 2; e <= 4; e++) begin
            tick();
            if (valid) saw_valid = 1;
        end
        launch(1, 1, 0);
        chk("abort_no_valid", saw_valid, 0);
        finish_op("abort_second", 1, 1, 0);

        launch(100, 3, 2);
        finish_op("pre_reset", 100, 3, 2);

        // Synchronous reset sampled in the middle of MUL.
        launch(7, 9, 5);
        for (int e = 2; e <= 5; e++) tick();
        reset = 1'b1;
        tick();
        chk_all_zero("reset_mid_E6");
        tick();
        chk_all_zero("reset_mid_E7");
        reset    = 1'b0;
        prev_div = 0;
        launch(12, 11, 10);
        finish_op("after_reset", 12, 11, 10);

        // Loopback through a behavioural divider.
        for (int i = 0; i < 40; i++) begin
            n = int'($urandom_range(0, 255));
            d = int'($urandom_range(1, 127));
            launch(n / d, d, n % d);
            finish_op("loop", n / d, d, n % d);
            chk("loop_consistent", int'(consistent), 1);
            chk("loop_dividend_orig", int'(dividend), n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
